regfile_sequencer: RTL and testbench

//  Multi-cycle controller for the 8x6-bit register file. Accepts packed instructions on a valid/ready port,

---
 rtl/regfile_ctrl_pkg.sv | 29 ++
 rtl/step_edge_detect.sv | 19 +
 rtl/regfile_sequencer.sv | 144 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file sequencer: FSM states,
// packed instruction layout and opcode classes.
package regfile_ctrl_pkg;

  localparam int AW      = 3;
  localparam int OPW     = 3;
  localparam int INSTR_W = OPW + 3 * AW;

  // Opcodes at or above OP_NOWB_MIN never write back; OP_HALT stops the sequencer.
  localparam logic [OPW-1:0] OP_NOWB_MIN = 3'd5;
  localparam logic [OPW-1:0] OP_HALT     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_STEP_WAIT,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  ra;
    logic [AW-1:0]  rb;
  } instr_t;

endpackage

// File: rtl/step_edge_detect.sv
// Rising-edge detector for the already-synchronised debug step level.
// o_rise is high while i_step is 1 and was 0 in the previous cycle.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_step,
  output logic o_rise
);

  logic r_step_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_step_d <= 1'b0;
    else     r_step_d <= i_step;
  end

  assign o_rise = i_step & ~r_step_d;

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle controller for the 8x6-bit register file: accepts one packed
// instruction at a time, sequences ALU start, optional single-step and write-back.
module regfile_sequencer
  import regfile_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               step_mode,
  input  logic               step,
  input  logic               alu_done,
  output logic               alu_start,
  output logic [OPW-1:0]     rf_op,
  output logic [AW-1:0]      rf_ra,
  output logic [AW-1:0]      rf_rb,
  output logic [AW-1:0]      rf_rd,
  output logic               rf_we,
  output logic               busy,
  output logic               halted,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  instr_t           r_fields;
  logic [7:0]       r_timer;
  logic [CNT_W-1:0] r_retired;
  logic             r_ready, r_alu_start, r_we, r_busy, r_halted, r_tout;
  logic             w_step_rise;
  instr_t           w_instr;

  assign w_instr = instr_t'(instr);

  step_edge_detect u_step_edge (
    .clk    (clk),
    .rst    (rst),
    .i_step (step),
    .o_rise (w_step_rise)
  );

  // NOTE: state and outputs use non-blocking assignments so every branch
  // below reads the pre-edge values; outputs are set on the edge that enters a state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fields    <= '0;
      r_timer     <= '0;
      r_retired   <= '0;
      r_ready     <= 1'b1;
      r_alu_start <= 1'b0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_tout      <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      r_we        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_fields    <= w_instr;
            r_state     <= S_DECODE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_alu_start <= (w_instr.op != OP_HALT);
          end
        end
        S_DECODE: begin
          if (r_fields.op == OP_HALT) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_retired <= r_retired + 1'b1;
          end else begin
            r_state <= S_EXEC;
            r_timer <= '0;
          end
        end
        S_EXEC: begin
          // A late alu_done on the final allowed cycle still wins over the timeout.
          if (alu_done) begin
            if (r_fields.op < OP_NOWB_MIN) begin
              if (step_mode) begin
                r_state <= S_STEP_WAIT;
              end else begin
                r_state <= S_WB;
                r_we    <= 1'b1;
              end
            end else begin
              r_retired <= r_retired + 1'b1;
              r_state   <= S_IDLE;
              r_ready   <= 1'b1;
              r_busy    <= 1'b0;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_tout  <= 1'b1;
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_STEP_WAIT: begin
          if (w_step_rise || !step_mode) begin
            r_state <= S_WB;
            r_we    <= 1'b1;
          end
        end
        S_WB: begin
          r_retired <= r_retired + 1'b1;
          r_state   <= S_IDLE;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign alu_start   = r_alu_start;
  assign rf_op       = r_fields.op;
  assign rf_ra       = r_fields.ra;
  assign rf_rb       = r_fields.rb;
  assign rf_rd       = r_fields.rd;
  assign rf_we       = r_we;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign timeout_err = r_tout;
  assign retired     = r_retired;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: a per-instruction timeline model sets
// expected outputs cycle by cycle and a negedge process compares them.
module tb_regfile_sequencer;
  import regfile_ctrl_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst, instr_valid, step_mode, step, alu_done;
  logic [INSTR_W-1:0] instr;
  logic instr_ready, alu_start, rf_we, busy, halted, timeout_err;
  logic [OPW-1:0] rf_op;
  logic [AW-1:0]  rf_ra, rf_rb, rf_rd;
  logic [CNT_W-1:0] retired;

  regfile_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .step_mode(step_mode), .step(step),
    .alu_done(alu_done), .alu_start(alu_start), .rf_op(rf_op), .rf_ra(rf_ra),
    .rf_rb(rf_rb), .rf_rd(rf_rd), .rf_we(rf_we), .busy(busy), .halted(halted),
    .timeout_err(timeout_err), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0, acc_at = 0, we_at = 0, we_count = 0, busy_cnt = 0;

  logic exp_ready, exp_start, exp_we, exp_busy, exp_halted, exp_tout;
  logic [OPW-1:0] exp_op;
  logic [AW-1:0]  exp_ra, exp_rb, exp_rd;
  logic [CNT_W-1:0] exp_retired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_reset();
    exp_ready = 1'b1; exp_start = 1'b0; exp_we = 1'b0; exp_busy = 1'b0;
    exp_halted = 1'b0; exp_tout = 1'b0; exp_op = '0; exp_ra = '0; exp_rb = '0;
    exp_rd = '0; exp_retired = '0;
  endtask

  task automatic go_idle();
    exp_ready = 1'b1;
    exp_busy  = 1'b0;
  endtask

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (rf_we) begin we_count++; we_at = cyc_cnt; end
    if (busy) busy_cnt++;
    check("instr_ready", 32'(instr_ready), 32'(exp_ready));
    check("alu_start",   32'(alu_start),   32'(exp_start));
    check("rf_we",       32'(rf_we),       32'(exp_we));
    check("busy",        32'(busy),        32'(exp_busy));
    check("halted",      32'(halted),      32'(exp_halted));
    check("timeout_err", 32'(timeout_err), 32'(exp_tout));
    check("rf_op",       32'(rf_op),       32'(exp_op));
    check("rf_ra",       32'(rf_ra),       32'(exp_ra));
    check("rf_rb",       32'(rf_rb),       32'(exp_rb));
    check("rf_rd",       32'(rf_rd),       32'(exp_rd));
    check("retired",     32'(retired),     32'(exp_retired));
  end

  // Starts in an IDLE cycle; done_at is the EXEC cycle index carrying alu_done,
  // step_seq gives the step level per STEP_WAIT cycle, drop_at clears step_mode.
  task automatic run_instr(input logic [INSTR_W-1:0] ins, input int done_at, input bit done_dec,
                           input bit smode, input bit step_pre, input logic [7:0] step_seq,
                           input int drop_at, input int rst_at);
    instr_t f;
    bit     done;
    logic   prev;
    f = instr_t'(ins);
    instr_valid = 1'b1; instr = ins; step_mode = smode; step = 1'b0; acc_at = cyc_cnt;
    cyc();
    instr_valid = 1'b0; instr = '0; alu_done = done_dec;
    exp_ready = 1'b0; exp_busy = 1'b1; exp_start = (f.op != OP_HALT);
    exp_op = f.op; exp_ra = f.ra; exp_rb = f.rb; exp_rd = f.rd;
    if (f.op == OP_HALT) begin
      cyc();
      alu_done = 1'b0; exp_start = 1'b0; exp_halted = 1'b1; exp_retired++;
      return;
    end
    done = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      cyc();
      exp_start = 1'b0; step = step_pre;
      if (k == rst_at) begin
        alu_done = 1'b0;
        #2;
        rst = 1'b1;
        exp_reset();
        #1;
        check("rst_async_we",      32'(rf_we),       0);
        check("rst_async_busy",    32'(busy),        0);
        check("rst_async_ready",   32'(instr_ready), 1);
        check("rst_async_retired", 32'(retired),     0);
        check("rst_async_tout",    32'(timeout_err), 0);
        cyc();
        rst = 1'b0; step = 1'b0; step_mode = 1'b0;
        return;
      end
      alu_done = (k == done_at);
      if (k == done_at) begin done = 1'b1; break; end
    end
    cyc();
    alu_done = 1'b0;
    if (!done) begin exp_tout = 1'b1; go_idle(); step = 1'b0; return; end
    if (f.op >= OP_NOWB_MIN) begin exp_retired++; go_idle(); step = 1'b0; return; end
    if (smode) begin
      prev = step_pre;
      for (int i = 0; i < 8; i++) begin
        step = step_seq[i];
        if (i == drop_at) step_mode = 1'b0;
        if ((step_seq[i] && !prev) || i == drop_at) break;
        prev = step_seq[i];
        cyc();
      end
      cyc();
    end
    exp_we = 1'b1;
    cyc();
    exp_we = 1'b0; exp_retired++; go_idle(); step = 1'b0; step_mode = 1'b0;
  endtask

  int we0, b0;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; step_mode = 1'b0; step = 1'b0; alu_done = 1'b0;
    exp_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ready",   32'(instr_ready), 1);
    check("reset_busy",    32'(busy),        0);
    check("reset_retired", 32'(retired),     0);

    // Basic write-back: ra=1 rb=2 rd=3, done one cycle after alu_start.
    run_instr(12'b000_011_001_010, 0, 0, 0, 0, 8'h00, -1, -1);
    check("wb_latency",  we_at - acc_at, 3);
    check("wb_count",    we_count,       1);
    check("retired_one", 32'(retired),   1);

    // No-write-back ops retire without a strobe.
    run_instr(12'b101_001_010_011, 0, 0, 0, 0, 8'h00, -1, -1);
    check("op5_no_we",   we_count,        1);
    check("op5_retired", 32'(retired),    2);
    check("op5_ready",   32'(instr_ready), 1);
    run_instr(12'b110_111_110_101, 3, 1, 0, 0, 8'h00, -1, -1);
    check("op6_retired", 32'(retired), 3);

    // Step held high on entry does not advance; drop then raise advances.
    run_instr(12'b010_100_011_110, 0, 0, 1, 1, 8'b0000_1011, -1, -1);
    check("step_we_count", we_count,      2);
    check("step_retired",  32'(retired),  4);
    // Leaving step mode while waiting releases the write-back.
    run_instr(12'b011_010_101_001, 1, 0, 1, 0, 8'h00, 2, -1);
    check("drop_retired", 32'(retired), 5);

    // ALU never answers: exactly TIMEOUT EXEC cycles, then sticky error.
    we0 = we_count; b0 = busy_cnt;
    run_instr(12'b001_110_010_100, 99, 0, 0, 0, 8'h00, -1, -1);
    check("tout_busy_cycles", busy_cnt - b0,    17);
    check("tout_flag",        32'(timeout_err), 1);
    check("tout_retired",     32'(retired),     5);
    check("tout_no_we",       we_count - we0,   0);

    // alu_done on the last permitted EXEC cycle still completes.
    run_instr(12'b100_001_001_001, TIMEOUT - 1, 0, 0, 0, 8'h00, -1, -1);
    check("late_done_retired", 32'(retired), 6);

    // Reset in EXEC abandons the instruction.
    we0 = we_count;
    run_instr(12'b000_101_100_011, 99, 0, 0, 0, 8'h00, -1, 2);
    check("rst_no_we", we_count - we0, 0);

    // Counter wrap.
    for (int n = 0; n < 255; n++) run_instr(12'b101_000_000_000, 0, 0, 0, 0, 8'h00, -1, -1);
    check("retired_255", 32'(retired), 255);
    run_instr(12'b101_000_000_000, 0, 0, 0, 0, 8'h00, -1, -1);
    check("retired_wrap", 32'(retired), 0);

    // HALT blocks further instructions until reset.
    run_instr(12'b111_000_000_000, 0, 0, 0, 0, 8'h00, -1, -1);
    instr_valid = 1'b1; instr = 12'b000_001_010_011;
    repeat (4) cyc();
    check("halt_halted",  32'(halted),      1);
    check("halt_ready",   32'(instr_ready), 0);
    check("halt_retired", 32'(retired),     1);
    instr_valid = 1'b0;
    rst = 1'b1;
    exp_reset();
    #1;
    check("halt_rst_halted", 32'(halted),      0);
    check("halt_rst_ready",  32'(instr_ready), 1);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
